// File: rtl/multdiv_sched_pkg.sv
// multdiv_sched_pkg: shared state encoding, opcode constants, default pass
// latency and the capture-slot layout used by the multdiv fault scheduler.
package multdiv_sched_pkg;

    localparam int unsigned LATENCY_DEF = 2;
    localparam int unsigned RES_W       = 32;
    localparam int unsigned SLOT_W      = RES_W + 1;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PASS0 = 3'd1,
        ST_PASS1 = 3'd2,
        ST_PASS2 = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // One pass result as captured from the datapath.
    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             exc;
    } slot_t;

endpackage

// File: rtl/multdiv_vote3.sv
// multdiv_vote3: combinational bitwise majority of three capture slots plus
// pairwise-mismatch flags.
//   slot0/1/2 : packed slot_t images of the three passes
//   maj_c     : bitwise majority (result and exc voted together)
//   mmXY_c    : slot X differs from slot Y
module multdiv_vote3
    import multdiv_sched_pkg::*;
(
    input  logic [SLOT_W-1:0] slot0,
    input  logic [SLOT_W-1:0] slot1,
    input  logic [SLOT_W-1:0] slot2,
    output logic [SLOT_W-1:0] maj_c,
    output logic              mm01_c,
    output logic              mm02_c,
    output logic              mm12_c
);

    assign maj_c  = (slot0 & slot1) | (slot0 & slot2) | (slot1 & slot2);
    assign mm01_c = (slot0 != slot1);
    assign mm02_c = (slot0 != slot2);
    assign mm12_c = (slot1 != slot2);

endmodule

// File: rtl/multdiv_fault_sched.sv
// multdiv_fault_sched: runs one mult/div request through the shared datapath
// in time-redundant passes and compares the pass results to detect transient
// faults. Optional macro MULTDIV_VOTE_EN adds a third pass with majority vote.
//   clock/aclr_n     : clock, async active-low reset
//   req_*            : request handshake, op, operands, per-pass inject mask
//   resp_*           : response handshake, result, exception and fault flags
//   fault_count      : saturating count of faulty responses
//   dp_*             : operand/flip drive to the datapath and its results
module multdiv_fault_sched
    import multdiv_sched_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEF,
    parameter int unsigned CNT_W   = 16
)(
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [31:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [2:0]       req_inject,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_result,
    output logic             resp_exception,
    output logic             resp_fault,
    output logic             resp_corrected,
    output logic             resp_uncorrectable,
    output logic [CNT_W-1:0] fault_count,
    output logic [31:0]      dp_operandA,
    output logic [15:0]      dp_operandB,
    output logic             dp_ctrl_flip,
    input  logic [31:0]      dp_mul_result,
    input  logic             dp_mul_exc,
    input  logic [31:0]      dp_div_result
);

    localparam int unsigned CYC_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [15:0]      op_b_q, op_b_d;
    logic [2:0]       inject_q, inject_d;
    logic             flip_q, flip_d;
    slot_t            slot0_q, slot0_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_result_q, resp_result_d;
    logic             resp_exc_q, resp_exc_d;
    logic             resp_fault_q, resp_fault_d;
    logic             resp_uncorr_q, resp_uncorr_d;
    logic [CNT_W-1:0] fault_count_q, fault_count_d;

    slot_t            cap;
    logic             last_cyc;

    // Datapath result of the current pass, selected by the latched op.
    assign cap.result = (op_q == OP_MULT) ? dp_mul_result : dp_div_result;
    assign cap.exc    = (op_q == OP_MULT) ? dp_mul_exc : 1'b0;
    assign last_cyc   = (cnt_q == CYC_W'(LATENCY - 1));

`ifdef MULTDIV_VOTE_EN
    slot_t             slot1_q, slot1_d;
    logic              resp_corr_q, resp_corr_d;
    logic [SLOT_W-1:0] maj_c;
    slot_t             maj_s;
    logic              mm01_c, mm02_c, mm12_c;

    // Third slot is the live capture, voted on the PASS2 capture edge.
    multdiv_vote3 u_vote (
        .slot0  (SLOT_W'(slot0_q)),
        .slot1  (SLOT_W'(slot1_q)),
        .slot2  (SLOT_W'(cap)),
        .maj_c  (maj_c),
        .mm01_c (mm01_c),
        .mm02_c (mm02_c),
        .mm12_c (mm12_c)
    );
    assign maj_s          = slot_t'(maj_c);
    assign resp_corrected = resp_corr_q;
`else
    logic unused_inject2;
    assign unused_inject2 = inject_q[2];
    assign resp_corrected = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        inject_d      = inject_q;
        flip_d        = 1'b0;
        slot0_d       = slot0_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_exc_d    = resp_exc_q;
        resp_fault_d  = resp_fault_q;
        resp_uncorr_d = resp_uncorr_q;
        fault_count_d = fault_count_q;
`ifdef MULTDIV_VOTE_EN
        slot1_d       = slot1_q;
        resp_corr_d   = resp_corr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d          = req_op;
                    op_a_d        = req_a;
                    op_b_d        = req_b;
                    inject_d      = req_inject;
                    req_ready_d   = 1'b0;
                    cnt_d         = '0;
                    resp_fault_d  = 1'b0;
                    resp_uncorr_d = 1'b0;
`ifdef MULTDIV_VOTE_EN
                    resp_corr_d   = 1'b0;
`endif
                    if (req_op == OP_DIV && req_b == 16'd0) begin
                        // Result is settled here; RESP raises valid one cycle later.
                        state_d       = ST_RESP;
                        resp_result_d = 32'd0;
                        resp_exc_d    = 1'b1;
                    end else begin
                        state_d = ST_PASS0;
                        flip_d  = req_inject[0];
                    end
                end
            end

            ST_PASS0: begin
                flip_d = inject_q[0];
                cnt_d  = cnt_q + CYC_W'(1);
                if (last_cyc) begin
                    slot0_d = cap;
                    cnt_d   = '0;
                    state_d = ST_PASS1;
                    flip_d  = inject_q[1];
                end
            end

            ST_PASS1: begin
                flip_d = inject_q[1];
                cnt_d  = cnt_q + CYC_W'(1);
                if (last_cyc) begin
                    cnt_d = '0;
                    if (cap == slot0_q) begin
                        state_d       = ST_RESP;
                        resp_valid_d  = 1'b1;
                        resp_result_d = cap.result;
                        resp_exc_d    = cap.exc;
                    end else begin
`ifdef MULTDIV_VOTE_EN
                        slot1_d = cap;
                        state_d = ST_PASS2;
                        flip_d  = inject_q[2];
`else
                        state_d       = ST_RESP;
                        resp_valid_d  = 1'b1;
                        resp_result_d = slot0_q.result;
                        resp_exc_d    = slot0_q.exc;
                        resp_fault_d  = 1'b1;
                        resp_uncorr_d = 1'b1;
`endif
                    end
                end
            end

`ifdef MULTDIV_VOTE_EN
            ST_PASS2: begin
                flip_d = inject_q[2];
                cnt_d  = cnt_q + CYC_W'(1);
                if (last_cyc) begin
                    cnt_d         = '0;
                    state_d       = ST_RESP;
                    resp_valid_d  = 1'b1;
                    resp_result_d = maj_s.result;
                    resp_exc_d    = maj_s.exc;
                    resp_fault_d  = 1'b1;
                    resp_corr_d   = 1'b1;
                    resp_uncorr_d = mm01_c & mm02_c & mm12_c;
                end
            end
`endif

            ST_RESP: begin
                resp_valid_d = 1'b1;
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                    if (resp_fault_q && fault_count_q != {CNT_W{1'b1}}) begin
                        fault_count_d = fault_count_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= OP_MULT;
            op_a_q        <= '0;
            op_b_q        <= '0;
            inject_q      <= '0;
            flip_q        <= 1'b0;
            slot0_q       <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_exc_q    <= 1'b0;
            resp_fault_q  <= 1'b0;
            resp_uncorr_q <= 1'b0;
            fault_count_q <= '0;
`ifdef MULTDIV_VOTE_EN
            slot1_q       <= '0;
            resp_corr_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            inject_q      <= inject_d;
            flip_q        <= flip_d;
            slot0_q       <= slot0_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_exc_q    <= resp_exc_d;
            resp_fault_q  <= resp_fault_d;
            resp_uncorr_q <= resp_uncorr_d;
            fault_count_q <= fault_count_d;
`ifdef MULTDIV_VOTE_EN
            slot1_q       <= slot1_d;
            resp_corr_q   <= resp_corr_d;
`endif
        end
    end

    assign req_ready          = req_ready_q;
    assign resp_valid         = resp_valid_q;
    assign resp_result        = resp_result_q;
    assign resp_exception     = resp_exc_q;
    assign resp_fault         = resp_fault_q;
    assign resp_uncorrectable = resp_uncorr_q;
    assign fault_count        = fault_count_q;
    assign dp_operandA        = op_a_q;
    assign dp_operandB        = op_b_q;
    assign dp_ctrl_flip       = flip_q;

endmodule

// File: tb/tb_multdiv_fault_sched.sv
// tb_multdiv_fault_sched: directed self-checking bench for multdiv_fault_sched.
// Includes a behavioural mult/div datapath that flips result bit 7 while
// dp_ctrl_flip is high. Honours MULTDIV_VOTE_EN for the fault-path expectations.
module tb_multdiv_fault_sched;

    localparam int unsigned LAT   = 2;
    localparam int unsigned CW    = 16;
    localparam logic [31:0] FMASK = 32'h0000_0080;

    logic          clock = 1'b0;
    logic          aclr_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [31:0]   req_a = '0;
    logic [15:0]   req_b = '0;
    logic [2:0]    req_inject = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_result;
    logic          resp_exception;
    logic          resp_fault;
    logic          resp_corrected;
    logic          resp_uncorrectable;
    logic [CW-1:0] fault_count;
    logic [31:0]   dp_operandA;
    logic [15:0]   dp_operandB;
    logic          dp_ctrl_flip;
    logic [31:0]   dp_mul_result;
    logic          dp_mul_exc;
    logic [31:0]   dp_div_result;

    int pass_cnt = 0;
    int total_cnt = 0;
    int flip_cycles = 0;

    always #5 clock = ~clock;

    // Behavioural datapath.
    logic signed [47:0] prod_full;
    logic signed [31:0] quot;
    assign prod_full     = $signed(dp_operandA) * $signed(dp_operandB);
    assign quot          = (dp_operandB == 16'd0) ? 32'sd0 : $signed(dp_operandA) / $signed(dp_operandB);
    assign dp_mul_result = prod_full[31:0] ^ (dp_ctrl_flip ? FMASK : 32'd0);
    assign dp_mul_exc    = (prod_full != {{16{prod_full[31]}}, prod_full[31:0]});
    assign dp_div_result = quot ^ (dp_ctrl_flip ? FMASK : 32'd0);

    always @(negedge clock) if (dp_ctrl_flip) flip_cycles++;

    multdiv_fault_sched #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .clock(clock), .aclr_n(aclr_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_inject(req_inject),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_exception(resp_exception),
        .resp_fault(resp_fault), .resp_corrected(resp_corrected),
        .resp_uncorrectable(resp_uncorrectable), .fault_count(fault_count),
        .dp_operandA(dp_operandA), .dp_operandB(dp_operandB),
        .dp_ctrl_flip(dp_ctrl_flip), .dp_mul_result(dp_mul_result),
        .dp_mul_exc(dp_mul_exc), .dp_div_result(dp_div_result)
    );

    // Counts edges after the accept edge until resp_valid is seen; -1 on timeout.
    task automatic wait_resp(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (resp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic issue(input logic op, input logic [31:0] a, input logic [15:0] b,
                         input logic [2:0] inj, output int n);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_inject = inj;
        @(posedge clock); #1;
        req_valid = 1'b0; req_inject = 3'b000;
        wait_resp(n);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        aclr_n = 1'b0;
        #12;
        total_cnt++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== 32'd0 ||
            resp_exception !== 1'b0 || resp_fault !== 1'b0 || resp_corrected !== 1'b0 ||
            resp_uncorrectable !== 1'b0 || fault_count !== 16'd0 ||
            dp_operandA !== 32'd0 || dp_operandB !== 16'd0 || dp_ctrl_flip !== 1'b0)
            $display("FAIL reset: rdy=%b vld=%b res=%h fc=%0d opA=%h flip=%b (want 1 0 0 0 0 0)",
                     req_ready, resp_valid, resp_result, fault_count, dp_operandA, dp_ctrl_flip);
        else pass_cnt++;
        @(negedge clock); aclr_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_mult_clean();
        int n;
        issue(1'b0, 32'd7, -16'sd3, 3'b000, n);
        total_cnt++;
        if (n !== 2 * LAT) $display("FAIL mult_latency: got %0d want %0d", n, 2 * LAT);
        else pass_cnt++;
        total_cnt++;
        if (resp_result !== 32'hFFFF_FFEB || resp_exception !== 1'b0 || resp_fault !== 1'b0)
            $display("FAIL mult_result: res=%h exc=%b flt=%b want ffffffeb 0 0",
                     resp_result, resp_exception, resp_fault);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL mult_busy: req_ready=%b want 0", req_ready);
        else pass_cnt++;
        handshake();
        total_cnt++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL mult_release: rdy=%b vld=%b want 1 0", req_ready, resp_valid);
        else pass_cnt++;
    endtask

    task automatic test_div_clean();
        int n;
        issue(1'b1, 32'd100, 16'd7, 3'b000, n);
        total_cnt++;
        if (n !== 2 * LAT || resp_result !== 32'd14 || resp_fault !== 1'b0 || resp_exception !== 1'b0)
            $display("FAIL div_pos: lat=%0d res=%h flt=%b want %0d 0000000e 0", n, resp_result, resp_fault, 2 * LAT);
        else pass_cnt++;
        handshake();
        issue(1'b1, -32'sd100, 16'd7, 3'b000, n);
        total_cnt++;
        if (n !== 2 * LAT || resp_result !== 32'hFFFF_FFF2 || resp_fault !== 1'b0)
            $display("FAIL div_neg: lat=%0d res=%h flt=%b want %0d fffffff2 0", n, resp_result, resp_fault, 2 * LAT);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_fault_inject();
        int n;
        int f0;
        f0 = flip_cycles;
        issue(1'b0, 32'd7, -16'sd3, 3'b010, n);
`ifdef MULTDIV_VOTE_EN
        total_cnt++;
        if (n !== 3 * LAT || resp_result !== 32'hFFFF_FFEB || resp_fault !== 1'b1 ||
            resp_corrected !== 1'b1 || resp_uncorrectable !== 1'b0)
            $display("FAIL fault_vote: lat=%0d res=%h f=%b c=%b u=%b want %0d ffffffeb 1 1 0",
                     n, resp_result, resp_fault, resp_corrected, resp_uncorrectable, 3 * LAT);
        else pass_cnt++;
`else
        total_cnt++;
        if (n !== 2 * LAT || resp_result !== 32'hFFFF_FFEB || resp_fault !== 1'b1 ||
            resp_corrected !== 1'b0 || resp_uncorrectable !== 1'b1)
            $display("FAIL fault_novote: lat=%0d res=%h f=%b c=%b u=%b want %0d ffffffeb 1 0 1",
                     n, resp_result, resp_fault, resp_corrected, resp_uncorrectable, 2 * LAT);
        else pass_cnt++;
`endif
        total_cnt++;
        if (flip_cycles - f0 !== LAT)
            $display("FAIL fault_flip_cycles: got %0d want %0d", flip_cycles - f0, LAT);
        else pass_cnt++;
        handshake();
        total_cnt++;
        if (fault_count !== 16'd1) $display("FAIL fault_count: got %0d want 1", fault_count);
        else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int n;
        int f0;
        f0 = flip_cycles;
        issue(1'b1, 32'd5, 16'd0, 3'b000, n);
        total_cnt++;
        if (n !== 1 || resp_result !== 32'd0 || resp_exception !== 1'b1 ||
            resp_fault !== 1'b0 || resp_uncorrectable !== 1'b0)
            $display("FAIL div_zero: lat=%0d res=%h exc=%b f=%b u=%b want 1 0 1 0 0",
                     n, resp_result, resp_exception, resp_fault, resp_uncorrectable);
        else pass_cnt++;
        handshake();
        total_cnt++;
        if (flip_cycles !== f0 || fault_count !== 16'd1)
            $display("FAIL div_zero_side: flips=%0d fc=%0d want 0 1", flip_cycles - f0, fault_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        int hold_bad;
        issue(1'b0, 32'd3, 16'd4, 3'b000, n);
        total_cnt++;
        if (n !== 2 * LAT || resp_result !== 32'd12)
            $display("FAIL hold_first: lat=%0d res=%h want %0d 0000000c", n, resp_result, 2 * LAT);
        else pass_cnt++;
        // Second request waits while the response is held.
        req_valid = 1'b1; req_op = 1'b0; req_a = 32'd2; req_b = 16'd5; req_inject = 3'b000;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (resp_valid !== 1'b1 || resp_result !== 32'd12 || req_ready !== 1'b0 ||
                resp_fault !== 1'b0 || dp_operandA !== 32'd3)
                hold_bad++;
        end
        total_cnt++;
        if (hold_bad !== 0) $display("FAIL hold_stable: bad cycles %0d want 0", hold_bad);
        else pass_cnt++;
        handshake();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL hold_release: req_ready=%b want 1", req_ready);
        else pass_cnt++;
        @(posedge clock); #1;
        req_valid = 1'b0;
        wait_resp(n);
        total_cnt++;
        if (n !== 2 * LAT || resp_result !== 32'd10)
            $display("FAIL hold_second: lat=%0d res=%h want %0d 0000000a", n, resp_result, 2 * LAT);
        else pass_cnt++;
        handshake();
    endtask

    task automatic test_reset_midpass();
        int n;
        int late;
        req_valid = 1'b1; req_op = 1'b0; req_a = 32'd9; req_b = 16'd9; req_inject = 3'b010;
        @(posedge clock); #1;
        req_valid = 1'b0; req_inject = 3'b000;
        repeat (LAT) @(posedge clock);
        #1;
        total_cnt++;
        if (dp_ctrl_flip !== 1'b1 || dp_operandA !== 32'd9)
            $display("FAIL midpass_active: flip=%b opA=%h want 1 00000009", dp_ctrl_flip, dp_operandA);
        else pass_cnt++;
        aclr_n = 1'b0;
        #2;
        total_cnt++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dp_ctrl_flip !== 1'b0 ||
            dp_operandA !== 32'd0 || fault_count !== 16'd0 || resp_result !== 32'd0)
            $display("FAIL midpass_reset: rdy=%b vld=%b flip=%b opA=%h fc=%0d res=%h want 1 0 0 0 0 0",
                     req_ready, resp_valid, dp_ctrl_flip, dp_operandA, fault_count, resp_result);
        else pass_cnt++;
        @(negedge clock); aclr_n = 1'b1;
        late = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (resp_valid !== 1'b0) late++;
        end
        total_cnt++;
        if (late !== 0) $display("FAIL midpass_dropped: resp_valid cycles %0d want 0", late);
        else pass_cnt++;
        issue(1'b0, 32'd3, 16'd4, 3'b000, n);
        total_cnt++;
        if (n !== 2 * LAT || resp_result !== 32'd12 || resp_fault !== 1'b0)
            $display("FAIL post_reset_mult: lat=%0d res=%h f=%b want %0d 0000000c 0",
                     n, resp_result, resp_fault, 2 * LAT);
        else pass_cnt++;
        handshake();
    endtask

    initial begin
        test_reset();
        test_mult_clean();
        test_div_clean();
        test_fault_inject();
        test_div_zero();
        test_back_to_back();
        test_reset_midpass();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
